// File: rtl/scv_cpclk_if.sv
// Bus bundle for scv_cpclk: clock-enable/hold controls towards the sequencer,
// phase strobes, hold acknowledge, core reset and machine-cycle count back.
interface scv_cpclk_if;
    logic        ce;
    logic        hold;
    logic        hold_ack;
    logic        cp1_posedge;
    logic        cp1_negedge;
    logic        cp2_posedge;
    logic        cp2_negedge;
    logic        cpu_resetb;
    logic [1:0]  phase;
    logic [31:0] cyc_cnt;

    modport master (
        output ce, hold,
        input  hold_ack, cp1_posedge, cp1_negedge, cp2_posedge, cp2_negedge,
        input  cpu_resetb, phase, cyc_cnt
    );

    modport slave (
        input  ce, hold,
        output hold_ack, cp1_posedge, cp1_negedge, cp2_posedge, cp2_negedge,
        output cpu_resetb, phase, cyc_cnt
    );
endinterface

// File: rtl/scv_cpclk.sv
// Clock-phase strobe generator and CPU reset stretcher for the upd7800 core,
// with a machine-cycle-aligned hold handshake. SCV_CPCLK_CYCCNT_EN adds a machine-cycle counter.
module scv_cpclk #(
    parameter int unsigned DIV          = 1,
    parameter int unsigned RES_HOLD_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    scv_cpclk_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HELD = 1'b1
    } hold_state_e;

    localparam logic [7:0] PRE_LAST_C = 8'(DIV - 32'd1);
    localparam logic [7:0] RC_INIT_C  = 8'(RES_HOLD_CYC);

    hold_state_e state_r;
    hold_state_e state_s;
    logic [7:0]  pre_r;
    logic [7:0]  pre_s;
    logic [1:0]  phase_r;
    logic [1:0]  phase_s;
    logic [3:0]  strobe_r;
    logic [3:0]  strobe_s;
    logic [7:0]  rc_r;
    logic [7:0]  rc_s;
    logic        resetb_r;
    logic        cyc_end_s;

    // Prescaler, phase sequencing and hold entry/exit at machine-cycle boundaries.
    always_comb begin
        state_s   = state_r;
        pre_s     = pre_r;
        phase_s   = phase_r;
        strobe_s  = 4'b0000;
        cyc_end_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.ce) begin
                    if (pre_r == PRE_LAST_C) begin
                        pre_s    = 8'd0;
                        strobe_s = 4'b0001 << phase_r;
                        phase_s  = phase_r + 2'd1;
                        if (phase_r == 2'd3) begin
                            // CP2_NEGEDGE closes the machine cycle: the only point a hold may start.
                            cyc_end_s = 1'b1;
                            if (bus.hold) begin
                                state_s = ST_HELD;
                            end else begin
                                state_s = ST_RUN;
                            end
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        pre_s = pre_r + 8'd1;
                    end
                end else begin
                    pre_s = pre_r;
                end
            end
            ST_HELD: begin
                pre_s   = 8'd0;
                phase_s = 2'd0;
                if (bus.hold) begin
                    state_s = ST_HELD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_RUN;
                pre_s   = 8'd0;
                phase_s = 2'd0;
            end
        endcase
    end

    // Reset stretch countdown: only emitted machine cycles count, held time does not.
    always_comb begin
        if (cyc_end_s && (rc_r != 8'd0)) begin
            rc_s = rc_r - 8'd1;
        end else begin
            rc_s = rc_r;
        end
    end

    // Sequencer state; RES clears everything and drops any in-flight strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_RUN;
            pre_r    <= 8'd0;
            phase_r  <= 2'd0;
            strobe_r <= 4'b0000;
            rc_r     <= RC_INIT_C;
            resetb_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pre_r    <= pre_s;
            phase_r  <= phase_s;
            strobe_r <= strobe_s;
            rc_r     <= rc_s;
            resetb_r <= (rc_r == 8'd0);
        end
    end

`ifdef SCV_CPCLK_CYCCNT_EN
    logic [31:0] cyc_cnt_r;

    // Machine-cycle counter, stepped alongside each emitted CP2_NEGEDGE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_r <= 32'd0;
        end else if (cyc_end_s) begin
            cyc_cnt_r <= cyc_cnt_r + 32'd1;
        end else begin
            cyc_cnt_r <= cyc_cnt_r;
        end
    end

    assign bus.cyc_cnt = cyc_cnt_r;
`else
    assign bus.cyc_cnt = 32'd0;
`endif

    assign bus.cp1_posedge = strobe_r[0];
    assign bus.cp1_negedge = strobe_r[1];
    assign bus.cp2_posedge = strobe_r[2];
    assign bus.cp2_negedge = strobe_r[3];
    assign bus.phase       = phase_r;
    assign bus.hold_ack    = (state_r == ST_HELD);
    assign bus.cpu_resetb  = resetb_r;

endmodule

// File: tb/tb_scv_cpclk.sv
// Self-checking bench for scv_cpclk: DIV=1 and DIV=3 instances share stimulus and are
// compared against an arithmetic reference model (strobe k emitted at qualified cycle DIV*(k+1)).
module tb_scv_cpclk;

    localparam int RHC = 16;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    logic hold;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    scv_cpclk_if bus_a ();
    scv_cpclk_if bus_b ();

    assign bus_a.ce   = ce;
    assign bus_a.hold = hold;
    assign bus_b.ce   = ce;
    assign bus_b.hold = hold;

    scv_cpclk #(.DIV(1), .RES_HOLD_CYC(RHC)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    scv_cpclk #(.DIV(3), .RES_HOLD_CYC(RHC)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Reference model: counts since the last run start plus machine cycles since reset.
    int       m_qual [2];
    int       m_emit [2];
    int       m_cp2n [2];
    bit       m_held [2];
    logic [3:0] m_strb [2];
    logic     m_resetb [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_qual[i]   = 0;
            m_emit[i]   = 0;
            m_cp2n[i]   = 0;
            m_held[i]   = 1'b0;
            m_strb[i]   = 4'b0000;
            m_resetb[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        logic nrb;
        int   k;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                nrb       = (m_cp2n[i] >= RHC);
                m_strb[i] = 4'b0000;
                if (m_held[i]) begin
                    if (!hold) begin
                        m_held[i] = 1'b0;
                        m_qual[i] = 0;
                        m_emit[i] = 0;
                    end
                end else if (ce) begin
                    m_qual[i]++;
                    if (m_qual[i] == div_of(i) * (m_emit[i] + 1)) begin
                        k = m_emit[i] % 4;
                        m_strb[i][k] = 1'b1;
                        m_emit[i]++;
                        if (k == 3) begin
                            m_cp2n[i]++;
                            if (hold) m_held[i] = 1'b1;
                        end
                    end
                end
                m_resetb[i] = nrb;
            end
        end
    endfunction

    function automatic logic [39:0] expv(input int i);
        logic [1:0]  ph;
        logic [31:0] cy;
        ph = m_held[i] ? 2'd0 : 2'(m_emit[i] % 4);
`ifdef SCV_CPCLK_CYCCNT_EN
        cy = 32'(m_cp2n[i]);
`else
        cy = 32'd0;
`endif
        return {m_strb[i], ph, m_held[i], m_resetb[i], cy};
    endfunction

    function automatic logic [39:0] obs(input int i);
        if (i == 0)
            return {bus_a.cp2_negedge, bus_a.cp2_posedge, bus_a.cp1_negedge, bus_a.cp1_posedge,
                    bus_a.phase, bus_a.hold_ack, bus_a.cpu_resetb, bus_a.cyc_cnt};
        else
            return {bus_b.cp2_negedge, bus_b.cp2_posedge, bus_b.cp1_negedge, bus_b.cp1_posedge,
                    bus_b.phase, bus_b.hold_ack, bus_b.cpu_resetb, bus_b.cyc_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ce   = 1'b1;
        hold = 1'b0;
        rst  = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== 40'd0) begin
                    n_fails++;
                    $display("FAIL reset_values dut%0d got %h exp %h", i, obs(i), 40'd0);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_div1_sequence();
        logic [3:0] exp_s;
        apply_reset();
        ce   = 1'b1;
        hold = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_s = 4'b0001 << ((k - 1) % 4);
            n_checks++;
            if ({obs(0)[39:36], obs(0)[35:34]} !== {exp_s, 2'(k % 4)}) begin
                n_fails++;
                $display("FAIL div1_seq edge %0d got %h exp %h", k, obs(0)[39:34], {exp_s, 2'(k % 4)});
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fails++;
                    $display("FAIL model_div1 dut%0d t=%0t got %h exp %h", i, $time, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_ce_toggle();
        int last = -1;
        bit prev_hit = 1'b0;
        bit hit;
        apply_reset();
        hold = 1'b0;
        for (int c = 0; c < 90; c++) begin
            ce = (c % 2 == 0);
            step();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fails++;
                    $display("FAIL model_ce dut%0d t=%0t got %h exp %h", i, $time, obs(i), expv(i));
                end
            end
            hit = |obs(1)[39:36];
            n_checks++;
            if ($countones(obs(1)[39:36]) > 1 || (hit && prev_hit)) begin
                n_fails++;
                $display("FAIL ce_width cycle %0d strobes %b prev_hit %0d", c, obs(1)[39:36], prev_hit);
            end
            if (hit) begin
                if (last >= 0) begin
                    n_checks++;
                    if (c - last != 6) begin
                        n_fails++;
                        $display("FAIL ce_spacing got %0d exp 6", c - last);
                    end
                end
                last = c;
            end
            prev_hit = hit;
        end
        ce = 1'b1;
    endtask

    task automatic test_reset_stretch();
        int n = 0;
        bit done = 1'b0;
        apply_reset();
        ce   = 1'b1;
        hold = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            step();
            if (n == RHC) begin
                n_checks++;
                if (bus_a.cpu_resetb !== 1'b1) begin
                    n_fails++;
                    $display("FAIL stretch_rise got %b exp 1", bus_a.cpu_resetb);
                end
`ifdef SCV_CPCLK_CYCCNT_EN
                n_checks++;
                if (bus_a.cyc_cnt !== 32'd16) begin
                    n_fails++;
                    $display("FAIL stretch_cyccnt got %0d exp 16", bus_a.cyc_cnt);
                end
`endif
                done = 1'b1;
            end else begin
                n_checks++;
                if (bus_a.cpu_resetb !== 1'b0) begin
                    n_fails++;
                    $display("FAIL stretch_early got %b exp 0 after %0d cp2n", bus_a.cpu_resetb, n);
                end
            end
            if (bus_a.cp2_negedge === 1'b1) n++;
        end
        if (!done) begin
            n_checks++;
            n_fails++;
            $display("FAIL stretch_timeout got %0d cp2n exp %0d", n, RHC);
        end
    endtask

    task automatic test_hold();
        int c = 0;
        apply_reset();
        ce   = 1'b1;
        hold = 1'b0;
        while (c < 20 && bus_a.cp1_negedge !== 1'b1) begin
            step();
            c++;
        end
        if (bus_a.cp1_negedge !== 1'b1) begin
            n_checks++;
            n_fails++;
            $display("FAIL hold_wait got %b exp 1", bus_a.cp1_negedge);
        end else begin
            step();
            n_checks++;
            if (bus_a.cp2_posedge !== 1'b1) begin
                n_fails++;
                $display("FAIL hold_cp2p got %b exp 1", bus_a.cp2_posedge);
            end
            hold = 1'b1;
            step();
            n_checks++;
            if ({bus_a.cp2_negedge, bus_a.hold_ack} !== 2'b11) begin
                n_fails++;
                $display("FAIL hold_entry got %b exp 11", {bus_a.cp2_negedge, bus_a.hold_ack});
            end
            for (int k = 0; k < 20; k++) begin
                step();
                n_checks++;
                if ({obs(0)[39:36], bus_a.hold_ack} !== 5'b00001) begin
                    n_fails++;
                    $display("FAIL hold_frozen cycle %0d got %b exp 00001", k, {obs(0)[39:36], bus_a.hold_ack});
                end
                for (int i = 0; i < 2; i++) begin
                    n_checks++;
                    if (obs(i) !== expv(i)) begin
                        n_fails++;
                        $display("FAIL model_hold dut%0d t=%0t got %h exp %h", i, $time, obs(i), expv(i));
                    end
                end
            end
            hold = 1'b0;
            step();
            n_checks++;
            if ({obs(0)[39:36], bus_a.hold_ack} !== 5'b00000) begin
                n_fails++;
                $display("FAIL hold_release got %b exp 00000", {obs(0)[39:36], bus_a.hold_ack});
            end
            step();
            n_checks++;
            if (obs(0)[39:36] !== 4'b0001) begin
                n_fails++;
                $display("FAIL hold_first_cp1p got %b exp 0001", obs(0)[39:36]);
            end
        end
    endtask

    task automatic test_res_midcycle();
        int c = 0;
        int n = 0;
        bit done = 1'b0;
        ce   = 1'b1;
        hold = 1'b0;
        while (c < 20 && bus_a.cp2_posedge !== 1'b1) begin
            step();
            c++;
        end
        n_checks++;
        if (bus_a.cp2_posedge !== 1'b1) begin
            n_fails++;
            $display("FAIL res_wait got %b exp 1", bus_a.cp2_posedge);
        end
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== 40'd0) begin
                n_fails++;
                $display("FAIL res_async dut%0d got %h exp %h", i, obs(i), 40'd0);
            end
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fails++;
                    $display("FAIL model_res dut%0d t=%0t got %h exp %h", i, $time, obs(i), expv(i));
                end
            end
            if (bus_a.cpu_resetb === 1'b1) begin
                n_checks++;
                if (n != RHC) begin
                    n_fails++;
                    $display("FAIL res_restretch got %0d cp2n exp %0d", n, RHC);
                end
                done = 1'b1;
            end
            if (bus_a.cp2_negedge === 1'b1) n++;
        end
        if (!done) begin
            n_checks++;
            n_fails++;
            $display("FAIL res_timeout got %0d cp2n exp %0d", n, RHC);
        end
    endtask

    task automatic test_random();
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fails++;
                    $display("FAIL model_rand dut%0d t=%0t got %h exp %h", i, $time, obs(i), expv(i));
                end
            end
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            rst = ($urandom_range(0, 399) == 0);
            if (rst) model_reset();
        end
        rst  = 1'b0;
        hold = 1'b0;
    endtask

    task automatic test_cyccnt();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        apply_reset();
        ce   = 1'b1;
        hold = 1'b0;
        repeat (4000) step();
`ifdef SCV_CPCLK_CYCCNT_EN
        exp_a = 32'd1000;
        exp_b = 32'd333;
`else
        exp_a = 32'd0;
        exp_b = 32'd0;
`endif
        n_checks++;
        if (bus_a.cyc_cnt !== exp_a) begin
            n_fails++;
            $display("FAIL cyccnt_a got %0d exp %0d", bus_a.cyc_cnt, exp_a);
        end
        n_checks++;
        if (bus_b.cyc_cnt !== exp_b) begin
            n_fails++;
            $display("FAIL cyccnt_b got %0d exp %0d", bus_b.cyc_cnt, exp_b);
        end
    endtask

    initial begin
        rst  = 1'b1;
        ce   = 1'b0;
        hold = 1'b0;
        model_reset();
        test_reset();
        test_div1_sequence();
        test_ce_toggle();
        test_reset_stretch();
        test_hold();
        test_res_midcycle();
        test_random();
        test_cyccnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/scv_cpclk.md
# scv_cpclk

Clock-phase and CPU-reset sequencer that sits directly upstream of the `upd7800` core. It derives the four single-cycle phase strobes `CP1_POSEDGE`, `CP1_NEGEDGE`, `CP2_POSEDGE` and `CP2_NEGEDGE` from the system clock. It also holds the core's `RESETB` low for a fixed number of machine cycles and provides a cycle-aligned freeze (hold) handshake for debug and DMA stalls.

## Interface
- `DIV`, default 1: qualified `CLK` cycles per phase tick; legal range 1..255.
- `RES_HOLD_CYC`, default 16: machine cycles (`CP2_NEGEDGE` strobes) for which `CPU_RESETB` stays low after `RES` deasserts; legal range 1..255.
- `CLK` in 1: system clock; all logic is on the rising edge.
- `RES` in 1: asynchronous, active-high reset.
- `CE` in 1: clock enable. Only `CLK` cycles with `CE`=1 advance the prescaler.
- `HOLD` in 1: freeze request. Level-sensitive.
- `HOLD_ACK` out 1: high while strobes are frozen.
- `CP1_POSEDGE` out 1: phase 0 strobe.
- `CP1_NEGEDGE` out 1: phase 1 strobe.
- `CP2_POSEDGE` out 1: phase 2 strobe.
- `CP2_NEGEDGE` out 1: phase 3 strobe.
- `CPU_RESETB` out 1: active-low reset to the core.
- `PHASE` out 2: index of the next phase to be emitted.
- `CYC_CNT` out 32: count of machine cycles; see Configuration.

## Operation
- State: prescaler `pre[7:0]`, `PHASE[1:0]`, hold flag, reset counter `rc[7:0]`, and a registered strobe vector.
- Tick: a tick occurs when `CE`=1, the block is not held, and `pre`==`DIV-1`.
  - On a tick: `pre`←0; the strobe for the current `PHASE` is registered high; `PHASE`←`PHASE`+1, wrapping 3→0.
  - Otherwise, when `CE`=1 and not held: `pre`←`pre`+1.
  - When `CE`=0, `pre` and `PHASE` hold their values.
- Strobes:
  - At most one strobe is high in any cycle.
  - Each strobe is high for exactly one `CLK` cycle.
  - Strobe order is always CP1P, CP1N, CP2P, CP2N. No phase is ever skipped.
- Hold state machine, states RUN and HELD:
  - RUN→HELD: occurs on the tick that emits `CP2_NEGEDGE` if `HOLD`=1 in that cycle. HELD is entered only at a machine-cycle boundary.
  - HELD→RUN: occurs in the first cycle with `HOLD`=0.
  - In HELD: `pre` is forced to 0 and `PHASE`=0.
  - `HOLD` asserted mid-cycle: the current machine cycle completes before HELD is entered.
- Reset stretcher:
  - `RES`=1 loads `rc`←`RES_HOLD_CYC` and forces `CPU_RESETB`=0.
  - Each emitted `CP2_NEGEDGE` decrements `rc` while `rc`≠0.
  - `CPU_RESETB` is `rc`==0, registered.
  - Strobes run while `CPU_RESETB` is low, because the core needs phase strobes during reset.
  - Held time does not count toward the reset hold.
- `RES` asserted mid-operation: all state is cleared immediately and asynchronously; any in-flight strobe is dropped.

## Timing
- Reset values: all strobes 0, `PHASE`=0, `pre`=0, `HOLD_ACK`=0, `CPU_RESETB`=0, `rc`=`RES_HOLD_CYC`, `CYC_CNT`=0.
- Strobe latency: a strobe is high in the cycle after its tick edge.
- With `DIV`=1 and `CE`=1: `CP1_POSEDGE` is high after the 1st rising `CLK` edge following `RES` deassertion. Each strobe repeats every 4 `CLK` cycles.
- With `DIV`=N and `CE`=1: strobes are N `CLK` cycles apart; machine-cycle period is 4N.
- `HOLD_ACK` latency:
  - Rises in the same cycle that `CP2_NEGEDGE` is high.
  - Falls one cycle after `HOLD` deasserts.
  - The first `CP1_POSEDGE` after release follows `DIV` further qualified cycles.
- `CPU_RESETB` rises one cycle after the `RES_HOLD_CYC`-th `CP2_NEGEDGE` strobe.
- `HOLD` and `RES` deasserting in the same cycle: `RES` takes priority; the block starts in RUN if `HOLD`=0, otherwise it follows normal hold entry.

## Configuration
- Macro: `SCV_CPCLK_CYCCNT_EN`.
- Defined: `CYC_CNT` increments on every emitted `CP2_NEGEDGE`, wraps from 0xFFFFFFFF to 0, and is cleared by `RES`.
- Undefined: `CYC_CNT` is tied to 0 and no counter logic is synthesized.

## Test plan
- `DIV`=1, `CE`=1, release `RES` → strobes repeat CP1P, CP1N, CP2P, CP2N with a 4-cycle period; `PHASE` sequence is 1, 2, 3, 0.
- `DIV`=3, `CE` toggling 1/0 every cycle → strobes are spaced 6 `CLK` cycles apart and remain one `CLK` wide.
- `RES_HOLD_CYC`=16 → `CPU_RESETB` rises exactly 1 cycle after the 16th `CP2_NEGEDGE`; with the macro defined, `CYC_CNT`=16 at that point.
- `HOLD` asserted in the cycle after `CP1_NEGEDGE` → CP2P and CP2N are still emitted, then `HOLD_ACK`=1 with no strobes for 20 cycles; release → `CP1_POSEDGE` appears `DIV` cycles after `HOLD_ACK` falls.
- `RES` pulsed for 1 cycle while `CP2_POSEDGE` is high → outputs return to their reset values; `CPU_RESETB` does not rise before a full `RES_HOLD_CYC` machine cycles have elapsed.
- Macro undefined → `CYC_CNT` reads 0 after 1000 machine cycles.
